// File: rtl/switch_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_ctrl_pkg : shared types, defaults and width helper for the         |
// |                   switch_toggle_ctrl slice                                |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package switch_ctrl_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int unsigned DEFAULT_NUM_REQ     = 4;
   localparam int unsigned DEFAULT_HOLD_CYCLES = 8;
   localparam int unsigned DEFAULT_CNT_W       = 8;

   // clog2 clamped to at least one bit so degenerate sizes still get a real vector
   function automatic int unsigned width_for(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, searching upward from        |
// |              rr_ptr with wrap; returns one-hot grant, index and valid     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rr_arbiter
   import switch_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
   parameter int unsigned PTR_W   = width_for(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx,
   output logic               valid
);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      sum       = '0;
      idx       = '0;
      if (enable) begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
               sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!valid && req[idx]) begin
               valid      = 1'b1;
               grant[idx] = 1'b1;
               grant_idx  = idx;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/switch_toggle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_toggle_ctrl : round-robin toggle arbiter for one shared switch     |
// |                      with a minimum dwell after each toggle.              |
// |                      Optional macro SWITCH_FORCE_EN adds force_en/val.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module switch_toggle_ctrl
   import switch_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ     = DEFAULT_NUM_REQ,
   parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
   parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
   input  logic               clock,
   input  logic               reset,
`ifdef SWITCH_FORCE_EN
   input  logic               force_en,
   input  logic               force_val,
`endif
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] ack,
   output logic               switch,
   output logic               busy,
   output logic [CNT_W-1:0]   toggle_count
);

   localparam int unsigned     PTR_W       = width_for(NUM_REQ);
   localparam int unsigned     HOLD_W      = width_for(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [PTR_W-1:0]  LAST_IDX    = PTR_W'(NUM_REQ - 1);

   state_t             state_q, state_d;
   logic [HOLD_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               switch_q, switch_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   toggle_count_q, toggle_count_d;

   logic               force_active;
   logic               force_value;
   logic [NUM_REQ-1:0] arb_grant;
   logic [PTR_W-1:0]   arb_idx;
   logic               arb_valid;

`ifdef SWITCH_FORCE_EN
   assign force_active = force_en;
   assign force_value  = force_val;
`else
   assign force_active = 1'b0;
   assign force_value  = 1'b0;
`endif

   // Arbiter is gated off in HOLD so req (even X) never reaches any output there
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req       (req),
      .rr_ptr    (rr_ptr_q),
      .enable    ((state_q == IDLE) && !force_active),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .valid     (arb_valid)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         rr_ptr_q       <= '0;
         switch_q       <= 1'b0;
         ack_q          <= '0;
         busy_q         <= 1'b0;
         toggle_count_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rr_ptr_q       <= rr_ptr_d;
         switch_q       <= switch_d;
         ack_q          <= ack_d;
         busy_q         <= busy_d;
         toggle_count_q <= toggle_count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (force_active) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_RELOAD;
               end
            end
            HOLD: begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - HOLD_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      switch_d       = switch_q;
      ack_d          = '0;
      busy_d         = (state_d == HOLD);
      toggle_count_d = toggle_count_q;
      rr_ptr_d       = rr_ptr_q;
      if (force_active) begin
         switch_d = force_value;
      end else if (arb_valid) begin
         switch_d       = ~switch_q;
         ack_d          = arb_grant;
         toggle_count_d = toggle_count_q + CNT_W'(1);
         rr_ptr_d       = (arb_idx == LAST_IDX) ? '0 : arb_idx + PTR_W'(1);
      end
   end

   assign ack          = ack_q;
   assign switch       = switch_q;
   assign busy         = busy_q;
   assign toggle_count = toggle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_toggle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_switch_toggle_ctrl : scoreboard bench for switch_toggle_ctrl with a    |
// |                         cycle-level reference model                       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_switch_toggle_ctrl;

   localparam int NR = 4;
   localparam int HC = 8;
   localparam int CW = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [NR-1:0] req   = '0;
   logic [NR-1:0] ack;
   logic          sw;
   logic          busy;
   logic [CW-1:0] tcount;
`ifdef SWITCH_FORCE_EN
   logic          force_en  = 1'b0;
   logic          force_val = 1'b0;
`endif

   always #5 clock = ~clock;

   switch_toggle_ctrl #(
      .NUM_REQ     (NR),
      .HOLD_CYCLES (HC),
      .CNT_W       (CW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
`ifdef SWITCH_FORCE_EN
      .force_en     (force_en),
      .force_val    (force_val),
`endif
      .req          (req),
      .ack          (ack),
      .switch       (sw),
      .busy         (busy),
      .toggle_count (tcount)
   );

   typedef struct {
      logic [NR-1:0] ack;
      logic          sw;
      logic          busy;
      int            cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   // Reference model: switch value, toggle total, next search start, cycles of dwell left
   bit            m_sw   = 1'b0;
   int            m_cnt  = 0;
   int            m_ptr  = 0;
   int            m_hold = 0;
   logic [NR-1:0] m_ack  = '0;

   task automatic model(input bit rst, input bit fe, input bit fv, input logic [NR-1:0] r);
      m_ack = '0;
      if (rst) begin
         m_sw = 1'b0; m_cnt = 0; m_ptr = 0; m_hold = 0;
      end else if (fe) begin
         m_sw   = fv;
         m_hold = 0;
      end else if (m_hold > 0) begin
         m_hold--;
      end else begin
         for (int k = 0; k < NR; k++) begin
            int g;
            g = (m_ptr + k) % NR;
            if (r[g] === 1'b1) begin
               m_ack[g] = 1'b1;
               m_sw     = ~m_sw;
               m_cnt    = (m_cnt + 1) % (1 << CW);
               m_ptr    = (g + 1) % NR;
               m_hold   = HC;
               break;
            end
         end
      end
      exp_q.push_back('{ack: m_ack, sw: m_sw, busy: (m_hold > 0), cnt: m_cnt});
   endtask

   task automatic step(input logic [NR-1:0] r, input bit rst, input bit fe = 1'b0, input bit fv = 1'b0);
      @(negedge clock);
      reset = rst;
      req   = r;
`ifdef SWITCH_FORCE_EN
      force_en  = fe;
      force_val = fv;
`endif
      model(rst, fe, fv, r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b0);
   endtask

   // Reset asserted between edges must clear outputs before the next rising edge
   task automatic async_reset_check();
      @(negedge clock);
      #2;
      reset = 1'b1;
      req   = '0;
      #1;
      total++;
      if (ack !== '0 || sw !== 1'b0 || busy !== 1'b0 || tcount !== '0) begin
         bad++;
         $display("FAIL async_reset: got ack=%b switch=%b busy=%b count=%0d, want all zero",
                  ack, sw, busy, tcount);
      end
      model(1'b1, 1'b0, 1'b0, '0);
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (ack !== e.ack || sw !== e.sw || busy !== e.busy || tcount !== CW'(e.cnt)) begin
               bad++;
               $display("FAIL outputs @%0t: got ack=%b switch=%b busy=%b count=%0d, want ack=%b switch=%b busy=%b count=%0d",
                        $time, ack, sw, busy, tcount, e.ack, e.sw, e.busy, e.cnt);
            end
         end
      end
   end

   initial begin
      logic [NR-1:0] pending;
      logic [NR-1:0] r;

      for (int i = 0; i < 3; i++) step('0, 1'b1);
      idle(2);

      // single request, one cycle wide
      step(4'b0010, 1'b0);
      idle(10);

      // all requesters held high from a fresh pointer
      step('0, 1'b1);
      for (int i = 0; i < 46; i++) step(4'b1111, 1'b0);
      idle(10);

      // request raised three cycles into the dwell and held until served
      step(4'b0001, 1'b0);
      idle(3);
      for (int i = 0; i < 7; i++) step(4'b0100, 1'b0);
      idle(12);

      // reset mid-dwell, then a fresh request is granted immediately
      step(4'b0010, 1'b0);
      idle(3);
      async_reset_check();
      step('0, 1'b0);
      step(4'b1000, 1'b0);
      idle(10);

`ifdef SWITCH_FORCE_EN
      step(4'b0001, 1'b0);
      idle(2);
      for (int i = 0; i < 4; i++) step(4'b0010, 1'b0, 1'b1, 1'b1);
      idle(2);
      step(4'b0010, 1'b0);
      idle(10);
      for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b1, 1'b0);
      step('0, 1'b0);
`endif

      // random traffic: each requester keeps its bit up until granted
      pending = '0;
      for (int i = 0; i < 400; i++) begin
         r = pending;
         if (m_hold > 0 && $urandom_range(0, 4) == 0) r = 'x;
`ifdef SWITCH_FORCE_EN
         if ($urandom_range(0, 40) == 0) step(r, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
         else step(r, 1'b0);
`else
         step(r, 1'b0);
`endif
         pending = pending & ~m_ack;
         if ($urandom_range(0, 2) == 0) pending = pending | NR'($urandom_range(0, (1 << NR) - 1));
      end
      idle(2);

      @(negedge clock);
      @(negedge clock);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
